// File: rtl/rx_defs_pkg.sv
// rtl/rx_defs_pkg.sv - shared state encodings and frame constants for the UART receiver
// Contents: rx_state_t (RX_IDLE/RX_START/RX_DATA/RX_STOP), OVERSAMPLE, MID_SAMPLE, DATA_BITS.
package rx_defs;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/rx_baud_tick.sv
// rtl/rx_baud_tick.sv - oversample prescaler producing a one-cycle tick every CLK_DIV cycles
// Ports: clk, rst_n (sync, active-low), en (count enable; counter held at 0 when low),
//        tick (high in the cycle the counter equals CLK_DIV-1).
module rx_baud_tick #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/rx_ctrl.sv
// rtl/rx_ctrl.sv - UART receive controller with 16x oversampling and a valid/ready holding register
// Ports: rx_clk, rx_rst_n (sync, active-low), rx_in (async serial line, idle high),
//        data_out/data_valid/data_ready (holding register handshake), frame_err (stop bit was 0),
//        overrun (sticky dropped-byte flag), err_clr (clears overrun), busy (frame in progress).
module rx_ctrl
    import rx_defs::*;
#(
    parameter int CLK_DIV = 27
) (
    input  logic       rx_clk,
    input  logic       rx_rst_n,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr,
    output logic       busy
);

    localparam int OS_W = $clog2(OVERSAMPLE);

    rx_state_t       state;
    rx_state_t       state_next;
    logic            sync1;
    logic            rxs;
    logic            tick;
    logic [OS_W-1:0] os_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            sample;
    logic            load;
    logic            accept;

    rx_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk   (rx_clk),
        .rst_n (rx_rst_n),
        .en    (state != RX_IDLE),
        .tick  (tick)
    );

    // Mid-bit sample point: the 8th tick of each 16-tick bit window.
    assign sample = tick && (os_cnt == OS_W'(MID_SAMPLE));
    assign load   = sample && (state == RX_STOP);
    assign accept = data_valid && data_ready;

    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:  if (!rxs) state_next = RX_START;
            RX_START: if (sample) state_next = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (sample && bit_cnt == 3'(DATA_BITS - 1)) state_next = RX_STOP;
            // Leaving at mid-stop gives half a bit of slack to catch the next start edge.
            RX_STOP:  if (sample) state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            sync1      <= 1'b1;
            rxs        <= 1'b1;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            sync1 <= rx_in;
            rxs   <= sync1;
            busy  <= (state_next != RX_IDLE);

            if (state == RX_IDLE) begin
                os_cnt <= '0;
            end else if (tick) begin
                os_cnt <= os_cnt + OS_W'(1);
            end

            if (state == RX_START && sample) begin
                bit_cnt <= '0;
            end else if (state == RX_DATA && sample) begin
                // LSB arrives first, so shift in from the top.
                shreg   <= {rxs, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end

            // A same-cycle accept frees the register, so the new byte may replace it.
            if (load && (!data_valid || data_ready)) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
                frame_err  <= ~rxs;
            end else if (accept) begin
                data_valid <= 1'b0;
            end

            // Setting has priority over err_clr so a drop in the clear cycle is not lost.
            if (load && data_valid && !data_ready) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_ctrl.sv
// tb/tb_rx_ctrl.sv - scoreboard bench for rx_ctrl with directed and randomized UART frames
module tb_rx_ctrl;

    localparam int CLK_DIV = 4;
    localparam int BIT_CYC = 16 * CLK_DIV;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    logic       rx_clk     = 1'b0;
    logic       rx_rst_n   = 1'b0;
    logic       rx_in      = 1'b1;
    logic       data_ready = 1'b0;
    logic       err_clr    = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;
    bit   rand_done = 1'b0;
    exp_t exp_q[$];

    rx_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .rx_clk     (rx_clk),
        .rx_rst_n   (rx_rst_n),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr),
        .busy       (busy)
    );

    always #5 rx_clk = ~rx_clk;

    always @(posedge rx_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every accepted byte must match the head of the expected queue.
    always @(negedge rx_clk) begin : monitor
        exp_t e;
        if (rx_rst_n && data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte_queue_size", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check("data_out", int'(data_out), int'(e.data));
                check("frame_err", int'(frame_err), int'(e.ferr));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge rx_clk);
        #1;
    endtask

    // Stop=0 frames hold the line low just past mid-stop, then release it high.
    task automatic send_frame(input logic [7:0] b, input bit stop);
        rx_in = 1'b0;
        step(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            step(BIT_CYC);
        end
        if (stop) begin
            rx_in = 1'b1;
            step(BIT_CYC);
        end else begin
            rx_in = 1'b0;
            step(40);
            rx_in = 1'b1;
        end
    endtask

    task automatic wait_busy(input logic lvl, input int max, input string name);
        int n;
        n = 0;
        while (busy !== lvl && n < max) begin
            @(negedge rx_clk);
            n++;
        end
        if (busy !== lvl) check(name, int'(busy), int'(lvl));
    endtask

    initial begin
        #(80000 * 10);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int c0;
        int c1;
        int n;

        step(3);
        check("rst_data_out", int'(data_out), 0);
        check("rst_data_valid", int'(data_valid), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_busy", int'(busy), 0);
        rx_rst_n = 1'b1;
        step(10);

        // 0xA5 with ready high: latency from START entry and single-cycle valid.
        data_ready = 1'b1;
        exp_q.push_back('{data: 8'hA5, ferr: 1'b0});
        fork
            send_frame(8'hA5, 1'b1);
            begin
                n = 0;
                while (!busy && n < 20) begin @(negedge rx_clk); n++; end
                c0 = cyc;
                n = 0;
                while (!data_valid && n < 700) begin @(negedge rx_clk); n++; end
                c1 = cyc;
                check("a5_latency", c1 - c0, 152 * CLK_DIV);
                @(negedge rx_clk);
                check("a5_valid_pulse", int'(data_valid), 0);
            end
        join
        step(10);

        // Break: stop sampled low, then immediate re-entry into START.
        exp_q.push_back('{data: 8'h00, ferr: 1'b1});
        fork
            send_frame(8'h00, 1'b0);
            begin
                wait_busy(1'b1, 20, "break_start_timeout");
                wait_busy(1'b0, 700, "break_idle_timeout");
                n = 0;
                while (!busy && n < 3) begin @(negedge rx_clk); n++; end
                check("break_resync_busy", int'(busy), 1);
            end
        join
        step(80);
        check("break_false_start_idle", int'(busy), 0);

        // Glitch: short low pulse is rejected at the start sample.
        rx_in = 1'b0;
        wait_busy(1'b1, 10, "glitch_busy_rise");
        step(5);
        rx_in = 1'b1;
        wait_busy(1'b0, 60, "glitch_return_idle");
        step(40);
        check("glitch_no_valid", int'(data_valid), 0);
        check("glitch_busy_low", int'(busy), 0);

        // Overrun: second byte dropped while the first is still held.
        data_ready = 1'b0;
        exp_q.push_back('{data: 8'h11, ferr: 1'b0});
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        step(5);
        check("ovr_valid_held", int'(data_valid), 1);
        check("ovr_data_kept", int'(data_out), 'h11);
        check("ovr_flag_set", int'(overrun), 1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("ovr_flag_cleared", int'(overrun), 0);
        data_ready = 1'b1;
        step(1);
        data_ready = 1'b0;
        check("ovr_valid_drop", int'(data_valid), 0);
        step(10);

        // Accept exactly in the stop-sample cycle of the second byte.
        exp_q.push_back('{data: 8'h11, ferr: 1'b0});
        send_frame(8'h11, 1'b1);
        exp_q.push_back('{data: 8'h22, ferr: 1'b0});
        fork
            send_frame(8'h22, 1'b1);
            begin
                n = 0;
                while (!busy && n < 20) begin @(negedge rx_clk); n++; end
                c0 = cyc;
                n = 0;
                while (cyc < c0 + 152 * CLK_DIV - 1 && n < 700) begin
                    @(posedge rx_clk);
                    #1;
                    n++;
                end
                data_ready = 1'b1;
                step(1);
                data_ready = 1'b0;
            end
        join
        step(5);
        check("same_cycle_valid", int'(data_valid), 1);
        check("same_cycle_data", int'(data_out), 'h22);
        check("same_cycle_no_ovr", int'(overrun), 0);
        data_ready = 1'b1;
        step(2);
        check("same_cycle_drained", int'(data_valid), 0);

        // Reset mid-DATA: partial frame discarded, next frame intact.
        rx_in = 1'b0;
        step(200);
        check("mid_frame_busy", int'(busy), 1);
        rx_rst_n = 1'b0;
        rx_in    = 1'b1;
        step(1);
        check("mid_rst_data_out", int'(data_out), 0);
        check("mid_rst_valid", int'(data_valid), 0);
        check("mid_rst_frame_err", int'(frame_err), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        check("mid_rst_busy", int'(busy), 0);
        rx_rst_n = 1'b1;
        step(100);
        check("mid_rst_no_output", int'(data_valid), 0);
        exp_q.push_back('{data: 8'h3C, ferr: 1'b0});
        send_frame(8'h3C, 1'b1);
        step(10);

        // Randomized frames with a randomly throttled consumer.
        fork
            begin
                logic [7:0] b;
                bit         s;
                for (int k = 0; k < 20; k++) begin
                    b = 8'($urandom);
                    s = ($urandom % 5) != 0;
                    exp_q.push_back('{data: b, ferr: ~s});
                    send_frame(b, s);
                    if (!s) step(80);
                    else step(int'($urandom % 20));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    data_ready = ($urandom % 4) != 0;
                    step(1);
                end
                data_ready = 1'b1;
            end
        join
        step(50);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_no_overrun", int'(overrun), 0);
        check("final_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
